fp16_mul_iter: RTL and testbench

FP16_MUL_ITER -- requirements
Module: fp16_mul_iter

---
 rtl/fp16_pkg.sv | 35 +++
 rtl/fp16_unpack.sv | 45 ++++
 rtl/fp16_mul_iter.sv | 146 ++++++++++++++
 tb/tb_fp16_mul_iter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared constants and types for the iterative binary16 significand multiplier.
// Build option FP16_MUL_RADIX4_EN selects 2 multiplier bits per cycle instead of 1.
package fp16_pkg;

  localparam int FP16_BIAS = 15;
  localparam int EXP_W     = 7;
  localparam int SIG_W     = 11;
  localparam int PROD_W    = 2 * SIG_W;
  localparam int MPLR_W    = 12;

  localparam logic [EXP_W-1:0] EXP_ZERO    = 7'h60;  // -32
  localparam logic [EXP_W-1:0] EXP_SPECIAL = 7'h1F;  // +31

`ifdef FP16_MUL_RADIX4_EN
  localparam int         STEP     = 2;
  localparam logic [3:0] LAST_CNT = 4'd5;
`else
  localparam int         STEP     = 1;
  localparam logic [3:0] LAST_CNT = 4'd10;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit order matches OP_TYPE: {zero, nan, inf}.
  typedef struct packed {
    logic zero;
    logic nan;
    logic inf;
  } op_class_t;

endpackage

// File: rtl/fp16_unpack.sv
// Combinational binary16 unpack: classification, leading-zero count and
// subnormal left-normalization into an unbiased exponent and 11-bit significand.
module fp16_unpack
  import fp16_pkg::*;
(
  input  logic [15:0]             op_i,
  output logic signed [EXP_W-1:0] exp_o,
  output logic [SIG_W-1:0]        sig_o,
  output logic                    is_zero_o,
  output logic                    is_inf_o,
  output logic                    is_nan_o
);

  logic [4:0]              e_field;
  logic [9:0]              frac;
  logic [3:0]              shift;
  logic signed [EXP_W-1:0] e_ext;

  assign e_field = op_i[14:10];
  assign frac    = op_i[9:0];
  assign e_ext   = {2'b00, e_field};

  assign is_zero_o = (e_field == 5'd0)  && (frac == 10'd0);
  assign is_inf_o  = (e_field == 5'd31) && (frac == 10'd0);
  assign is_nan_o  = (e_field == 5'd31) && (frac != 10'd0);

  // Ascending scan: the highest set fraction bit writes last and sets the shift.
  always_comb begin
    shift = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (frac[i]) shift = 4'(10 - i);
    end
  end

  always_comb begin
    if (e_field == 5'd0) begin
      sig_o = {1'b0, frac} << shift;
      exp_o = -7'sd14 - $signed({3'b000, shift});
    end else begin
      sig_o = {1'b1, frac};
      exp_o = e_ext - 7'(FP16_BIAS);
    end
  end

endmodule

// File: rtl/fp16_mul_iter.sv
// Iterative binary16 multiplier front end: unpacks operands, classifies specials
// and builds the raw 11x11 significand product by shift-add (FP16_MUL_RADIX4_EN: radix 4).
// Handshake: a transfer happens on an edge where valid and ready are both high;
// OUT_VALID and all result outputs hold steady until OUT_READY is seen.
module fp16_mul_iter
  import fp16_pkg::*;
(
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [15:0]                   A,
  input  logic [15:0]                   B,
  input  logic                          IN_VALID,
  output logic                          IN_READY,
  output logic                          OUT_VALID,
  input  logic                          OUT_READY,
  output logic                          SIGN,
  output logic signed [1:0][EXP_W-1:0]  EXPONENT,
  output logic [PROD_W-1:0]             SIGNIFICAND_MUL,
  output logic [2:0]                    OP_TYPE,
  output state_e                        STATE_DBG
);

  logic signed [EXP_W-1:0] exp_a, exp_b;
  logic [SIG_W-1:0]        sig_a, sig_b;
  logic                    zero_a, inf_a, nan_a;
  logic                    zero_b, inf_b, nan_b;

  fp16_unpack u_unpack_a (
    .op_i      (A),
    .exp_o     (exp_a),
    .sig_o     (sig_a),
    .is_zero_o (zero_a),
    .is_inf_o  (inf_a),
    .is_nan_o  (nan_a)
  );

  fp16_unpack u_unpack_b (
    .op_i      (B),
    .exp_o     (exp_b),
    .sig_o     (sig_b),
    .is_zero_o (zero_b),
    .is_inf_o  (inf_b),
    .is_nan_o  (nan_b)
  );

  op_class_t cls_d;
  logic      special_d;

  // inf x zero is invalid and therefore classed as NaN.
  always_comb begin
    cls_d.nan  = nan_a | nan_b | (inf_a & zero_b) | (zero_a & inf_b);
    cls_d.inf  = ~cls_d.nan & (inf_a | inf_b);
    cls_d.zero = ~cls_d.nan & ~cls_d.inf & (zero_a | zero_b);
    special_d  = cls_d.nan | cls_d.inf | cls_d.zero;
  end

  state_e                       state_q;
  logic [3:0]                   cnt_q;
  logic                         in_ready_q;
  logic                         out_valid_q;
  logic                         sign_q;
  logic signed [1:0][EXP_W-1:0] exp_q;
  logic [PROD_W-1:0]            acc_q;
  logic [PROD_W-1:0]            mcand_q;
  logic [MPLR_W-1:0]            mplier_q;
  op_class_t                    op_q;
  logic [PROD_W-1:0]            pp_d;

`ifdef FP16_MUL_RADIX4_EN
  always_comb begin
    pp_d = (mplier_q[0] ? mcand_q : '0) + (mplier_q[1] ? (mcand_q << 1) : '0);
  end
`else
  always_comb begin
    pp_d = mplier_q[0] ? mcand_q : '0;
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      op_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (IN_VALID && in_ready_q) begin
            in_ready_q <= 1'b0;
            sign_q     <= A[15] ^ B[15];
            cnt_q      <= 4'd0;
            acc_q      <= '0;
            if (special_d) begin
              exp_q       <= cls_d.zero ? {EXP_ZERO, EXP_ZERO} : {EXP_SPECIAL, EXP_SPECIAL};
              op_q        <= cls_d;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              exp_q    <= {exp_b, exp_a};
              op_q     <= '0;
              mcand_q  <= {{(PROD_W-SIG_W){1'b0}}, sig_a};
              mplier_q <= {1'b0, sig_b};
              state_q  <= MUL;
            end
          end
        end
        MUL: begin
          acc_q    <= acc_q + pp_d;
          mcand_q  <= mcand_q << STEP;
          mplier_q <= mplier_q >> STEP;
          if (cnt_q == LAST_CNT) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          if (OUT_READY) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            cnt_q       <= 4'd0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign IN_READY        = in_ready_q;
  assign OUT_VALID       = out_valid_q;
  assign SIGN            = sign_q;
  assign EXPONENT        = exp_q;
  assign SIGNIFICAND_MUL = acc_q;
  assign OP_TYPE         = op_q;
  assign STATE_DBG       = state_q;

endmodule

// File: tb/tb_fp16_mul_iter.sv
// Self-checking bench for fp16_mul_iter: directed vector table, handshake and
// reset corner sequences, and randomized operands against a behavioural model.
module tb_fp16_mul_iter;
  import fp16_pkg::*;

`ifdef FP16_MUL_RADIX4_EN
  localparam int FIN_LAT = 7;
`else
  localparam int FIN_LAT = 12;
`endif

  logic                         CLK = 1'b0;
  logic                         RST = 1'b1;
  logic [15:0]                  A = '0;
  logic [15:0]                  B = '0;
  logic                         IN_VALID = 1'b0;
  logic                         IN_READY;
  logic                         OUT_VALID;
  logic                         OUT_READY = 1'b0;
  logic                         SIGN;
  logic signed [1:0][6:0]       EXPONENT;
  logic [21:0]                  SIGNIFICAND_MUL;
  logic [2:0]                   OP_TYPE;
  state_e                       STATE_DBG;

  fp16_mul_iter dut (
    .CLK             (CLK),
    .RST             (RST),
    .A               (A),
    .B               (B),
    .IN_VALID        (IN_VALID),
    .IN_READY        (IN_READY),
    .OUT_VALID       (OUT_VALID),
    .OUT_READY       (OUT_READY),
    .SIGN            (SIGN),
    .EXPONENT        (EXPONENT),
    .SIGNIFICAND_MUL (SIGNIFICAND_MUL),
    .OP_TYPE         (OP_TYPE),
    .STATE_DBG       (STATE_DBG)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [39:0] exp_q[$];

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [39:0] out_vec();
    return {SIGN, EXPONENT, SIGNIFICAND_MUL, OP_TYPE};
  endfunction

  // ---------------- reference model ----------------
  function automatic void dec(input logic [15:0] x, output int e, output int s,
                              output bit z, output bit inf, output bit nan);
    int ef;
    int f;
    ef  = int'(x[14:10]);
    f   = int'(x[9:0]);
    z   = (ef == 0) && (f == 0);
    inf = (ef == 31) && (f == 0);
    nan = (ef == 31) && (f != 0);
    if (ef == 0) begin
      e = -14;
      s = f;
      while (s != 0 && s < 1024) begin
        s = s * 2;
        e = e - 1;
      end
    end else begin
      e = ef - 15;
      s = f + 1024;
    end
  endfunction

  function automatic logic [39:0] model(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, sa, sb, e0, e1;
    bit za, ia, na, zb, ib, nb;
    logic [2:0]  op;
    logic [21:0] sig;
    dec(a, ea, sa, za, ia, na);
    dec(b, eb, sb, zb, ib, nb);
    sig = '0;
    if (na || nb || (ia && zb) || (za && ib)) begin
      op = 3'b010; e0 = 31; e1 = 31;
    end else if (ia || ib) begin
      op = 3'b001; e0 = 31; e1 = 31;
    end else if (za || zb) begin
      op = 3'b100; e0 = -32; e1 = -32;
    end else begin
      op = 3'b000; e0 = ea; e1 = eb;
      sig = 22'(sa * sb);
    end
    return {a[15] ^ b[15], 7'(e1), 7'(e0), sig, op};
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold,
                        input bit noise, input string name);
    int guard;
    int lat;
    logic [39:0] expv;
    logic [39:0] snap;
    guard = 0;
    while (!IN_READY && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    check({name, " in_ready"}, {39'd0, IN_READY}, 40'd1);
    if (!IN_READY) return;
    A = a;
    B = b;
    IN_VALID = 1'b1;
    exp_q.push_back(model(a, b));
    @(negedge CLK);
    lat = 1;
    if (noise) begin
      A = 16'($urandom);
      B = 16'($urandom);
    end else begin
      IN_VALID = 1'b0;
    end
    while (!OUT_VALID && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
    expv = exp_q.pop_front();
    check({name, " latency"}, 40'(lat), (expv[2:0] != 3'b000) ? 40'd1 : 40'(FIN_LAT));
    check({name, " result"}, out_vec(), expv);
    snap = out_vec();
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      check({name, " hold data"}, out_vec(), snap);
      check({name, " hold hs"}, {38'd0, OUT_VALID, IN_READY}, 40'd2);
    end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
    check({name, " transfer"}, {38'd0, OUT_VALID, IN_READY}, 40'd1);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    int          e0;
    int          e1;
    logic [21:0] sig;
    logic [2:0]  op;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [39:0] expv;
    logic [15:0] ra, rb;
    bit          ov_seen;

    vecs[0] = '{16'h3C00, 16'h3C00, 1'b0,   0,   0, 22'h100000, 3'b000};
    vecs[1] = '{16'h4000, 16'hC200, 1'b1,   1,   1, 22'h180000, 3'b000};
    vecs[2] = '{16'h0001, 16'h3C00, 1'b0, -24,   0, 22'h100000, 3'b000};
    vecs[3] = '{16'h7C00, 16'h0000, 1'b0,  31,  31, 22'h000000, 3'b010};
    vecs[4] = '{16'h0000, 16'h3C00, 1'b0, -32, -32, 22'h000000, 3'b100};
    vecs[5] = '{16'h3C00, 16'hFC00, 1'b1,  31,  31, 22'h000000, 3'b001};
    vecs[6] = '{16'h7E00, 16'h4000, 1'b0,  31,  31, 22'h000000, 3'b010};
    vecs[7] = '{16'h03FF, 16'h7BFF, 1'b0, -15,  15, 22'h3FE802, 3'b000};
    vecs[8] = '{16'h8000, 16'h7C00, 1'b1,  31,  31, 22'h000000, 3'b010};
    vecs[9] = '{16'h0200, 16'h0200, 1'b0, -15, -15, 22'h100000, 3'b000};

    // Reset state
    repeat (3) @(negedge CLK);
    check("reset outputs", out_vec(), 40'd0);
    check("reset hs", {38'd0, OUT_VALID, IN_READY}, 40'd0);
    check("reset state", {38'd0, STATE_DBG}, {38'd0, IDLE});
    RST = 1'b0;
    @(negedge CLK);
    check("ready after reset", {39'd0, IN_READY}, 40'd1);

    // Directed table, checked against hand-derived expectations
    for (int i = 0; i < 10; i++) begin
      int lat;
      expv = {vecs[i].s, 7'(vecs[i].e1), 7'(vecs[i].e0), vecs[i].sig, vecs[i].op};
      while (!IN_READY) @(negedge CLK);
      A = vecs[i].a;
      B = vecs[i].b;
      IN_VALID = 1'b1;
      @(negedge CLK);
      IN_VALID = 1'b0;
      lat = 1;
      while (!OUT_VALID && lat < 40) begin
        @(negedge CLK);
        lat++;
      end
      check($sformatf("vec%0d latency", i), 40'(lat),
            (vecs[i].op != 3'b000) ? 40'd1 : 40'(FIN_LAT));
      check($sformatf("vec%0d result", i), out_vec(), expv);
      OUT_READY = 1'b1;
      @(negedge CLK);
      OUT_READY = 1'b0;
      check($sformatf("vec%0d transfer", i), {38'd0, OUT_VALID, IN_READY}, 40'd1);
    end

    // Backpressure: OUT_READY low 5 cycles with IN_VALID noise while busy
    run_op(16'h3C00, 16'h4000, 5, 1'b1, "hold5");
    run_op(16'h7C00, 16'h3C00, 3, 1'b1, "hold_special");

    // Reset during MUL at count 5
    while (!IN_READY) @(negedge CLK);
    A = 16'h4000;
    B = 16'h3E00;
    IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    repeat (5) @(negedge CLK);
    check("pre-abort busy", {38'd0, OUT_VALID, IN_READY}, 40'd0);
    RST = 1'b1;
    @(negedge CLK);
    check("abort outputs", out_vec(), 40'd0);
    check("abort hs", {38'd0, OUT_VALID, IN_READY}, 40'd0);
    RST = 1'b0;
    @(negedge CLK);
    check("abort ready", {39'd0, IN_READY}, 40'd1);
    ov_seen = 1'b0;
    repeat (15) begin
      @(negedge CLK);
      if (OUT_VALID) ov_seen = 1'b1;
    end
    check("abort no out_valid", {39'd0, ov_seen}, 40'd0);
    run_op(16'h4000, 16'h3E00, 0, 1'b0, "after_abort");

    // Randomized operands against the reference model
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0: ra = {1'($urandom), 5'd31, (($urandom_range(0, 1) == 0) ? 10'd0 : 10'($urandom))};
        1: ra = {1'($urandom), 5'd0, 10'($urandom)};
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: rb = {1'($urandom), 15'd0};
        1: rb = {1'($urandom), 5'd0, 10'($urandom)};
        default: rb = 16'($urandom);
      endcase
      run_op(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
    end

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
